// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with registered one-hot grant and hold-limit preemption
// Ports: clk, rst (async, active-high), req[3:0] level requests,
//        gnt[3:0] one-hot grant, gnt_idx[1:0] encoded owner, gnt_valid = |gnt,
//        preempt one-cycle pulse on the first cycle of a grant taken by the hold limit.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state;
  logic [1:0] o, ptr, k, w;
  logic [7:0] cnt;
  logic [3:0] cand, rot;
  logic [7:0] rot2;
  logic       hit, lim, take;
  // Outside IDLE the owner is masked out; on release its bit is already clear,
  // and on preemption this is exactly the required exclusion.
  always_comb begin
    cand = state == GRANT ? req & ~(4'b0001 << o) : req;
    rot2 = {cand, cand} >> ptr;
    rot  = rot2[3:0];
    k    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    w    = ptr + k;
    hit  = |cand;
    lim  = cnt == 8'(MAX_HOLD);
    take = state == IDLE || !req[o] || (lim && hit);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o         <= '0;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      if (take && hit) begin
        state     <= GRANT;
        o         <= w;
        ptr       <= w + 2'd1;
        cnt       <= 8'd1;
        gnt       <= 4'b0001 << w;
        gnt_idx   <= w;
        gnt_valid <= 1'b1;
        preempt   <= state == GRANT && req[o];
      end else if (take) begin
        state     <= IDLE;
        gnt       <= '0;
        gnt_idx   <= '0;
        gnt_valid <= 1'b0;
      end else begin
        cnt <= lim ? cnt : cnt + 8'd1;
      end
    end
  end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as the 4:2 encoded select path, between four clients. It issues a registered one-hot grant plus its 2-bit encoded index. Grants rotate fairly, and a hold limit preempts an owner that keeps its request asserted while others wait. The block sits in front of the shared resource: `gnt_idx` drives the resource select, and `gnt_valid` qualifies it.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles an owner keeps the grant while another requester is waiting. Legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  request vector; bit i is requester i, level-sensitive.
- `gnt`  out  4  registered one-hot grant; all zero when no owner.
- `gnt_idx`  out  2  binary index of the set `gnt` bit; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  equals `|gnt`.
- `preempt`  out  1  one-cycle pulse, coincident with the first cycle of a grant taken by hold-limit preemption.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - Owner `o` (2 bits).
  - Priority pointer `ptr` (2 bits).
  - Hold counter `cnt` (8 bits, saturating at `MAX_HOLD`).
- Winner search examines `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4) and picks the first set request.
- IDLE:
  - `req`=0000: stay in IDLE.
  - Otherwise: winner `w` → GRANT, `o`=`w`, `ptr`=`w+1`, `cnt`=1.
- GRANT, `req[o]`=0 (release):
  - Another request is set: the winner takes the grant on the same edge, with no idle gap. `ptr`=`w+1`, `cnt`=1, `preempt`=0.
  - No request is set: → IDLE, all grant outputs 0.
- GRANT, `req[o]`=1, `cnt`=`MAX_HOLD`, another request set (preemption):
  - Winner is searched with `o` excluded.
  - Grant moves to the winner, `ptr`=`w+1`, `cnt`=1, `preempt`=1 for that one cycle.
- GRANT, `req[o]`=1, otherwise: keep the grant; `cnt` increments, saturating at `MAX_HOLD`.
- With no contention the owner holds the grant indefinitely; `preempt` never fires.
- Invariants:
  - `gnt` is always zero or one-hot.
  - `gnt_idx` equals the encoded `gnt`.
  - A granted `req` bit was set at the granting edge.
- Reset:
  - `gnt`=0000, `gnt_idx`=00, `gnt_valid`=0, `preempt`=0.
  - `ptr`=0, `cnt`=0, state IDLE.
  - Assertion mid-grant clears all outputs immediately, without waiting for a clock edge.
  - First arbitration is on the first rising edge after `rst` deasserts.

## Timing
- All outputs are registered; there is no combinational path from `req` to the outputs.
- Grant latency from IDLE is 1 cycle: `req` sampled at edge k drives `gnt` valid after edge k.
- Release latency is 1 cycle: the owner drops `req` before edge k, and `gnt` changes after edge k.
- Handover between owners is zero-gap: the next owner's grant follows the release edge directly.
- Under continuous full contention, each owner holds exactly `MAX_HOLD` cycles.
- `preempt` is high for exactly 1 cycle per preemption; it is never high while `gnt_valid`=0.

## Test plan
- Reset: hold `rst`=1 with `req`=1111 for 3 cycles → `gnt`=0000, `gnt_idx`=00, `gnt_valid`=0, `preempt`=0 throughout.
- Single requester: `req`=0100 → one edge later `gnt`=0100, `gnt_idx`=10, `gnt_valid`=1. Then `req`=0000 → `gnt`=0000 after the next edge.
- Rotation:
  - Setup: `MAX_HOLD`=2, `req`=1111 held.
  - `gnt` sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
  - `preempt`=1 on the first cycle of each new owner after the first.
- No contention: `MAX_HOLD`=8, `req`=0010 for 20 cycles → `gnt`=0010 for all 20 cycles, `preempt` never asserted.
- Zero-gap handover:
  - Requester 0 owns, `req`=0101.
  - Drop bit 0 → next cycle `gnt`=0100, `gnt_idx`=10, `preempt`=0, with no cycle of `gnt_valid`=0.
- Async reset: assert `rst` mid-cycle while `gnt`=1000 → outputs go to 0 before the next clock edge. Release `rst` with `req`=1000 → `gnt`=1000 one edge later.
